// File: rtl/msx_mem_arb_pkg.sv
// Shared types for the MSX SDRAM byte-port arbiter: FSM states, grant owner, downstream command.
package msx_mem_arb_pkg;

    localparam int ADDR_W_DEF = 25;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_LDR} grant_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [7:0]            din;
    } mem_cmd_t;

    // With both requesters pending, the one that did not win last time goes next.
    function automatic grant_t pick_grant(input logic cpu, input logic ldr, input grant_t last);
        if (cpu && ldr)
            return (last == GNT_CPU) ? GNT_LDR : GNT_CPU;
        else if (cpu)
            return GNT_CPU;
        else
            return GNT_LDR;
    endfunction

endpackage

// File: rtl/msx_ldr_buf.sv
// One-entry holding slot for ioctl loader bytes; full doubles as the loader backpressure.
module msx_ldr_buf
    import msx_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_din,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_ovf,
    output mem_cmd_t          o_cmd
);

    logic     r_full;
    logic     r_ovf;
    mem_cmd_t r_cmd;
    logic     w_free;

    // A flush on the same edge frees the slot, so a coincident write is accepted.
    assign w_free = ~r_full | i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
            r_cmd  <= '0;
        end else begin
            if (i_wr && w_free) begin
                r_full     <= 1'b1;
                r_cmd.we   <= 1'b1;
                r_cmd.addr <= ADDR_W_DEF'(i_addr);
                r_cmd.din  <= i_din;
            end else if (i_flush) begin
                r_full <= 1'b0;
            end
            if (i_wr && !w_free)
                r_ovf <= 1'b1;
        end
    end

    assign o_full = r_full;
    assign o_ovf  = r_ovf;
    assign o_cmd  = r_cmd;

endmodule

// File: rtl/msx_mem_arbiter.sv
// Shares the SDRAM byte port between the MSX CPU bus and the ioctl loader, one req/ack at a time.
// Optional mem_ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module msx_mem_arbiter
    import msx_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_ioctl_download,
    input  logic              i_ioctl_wr,
    input  logic [ADDR_W-1:0] i_ioctl_addr,
    input  logic [7:0]        i_ioctl_dout,
    output logic              o_ioctl_wait,
    output logic              o_ldr_ovf,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [7:0]        i_cpu_din,
    output logic [7:0]        o_cpu_dout,
    output logic              o_cpu_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_din,
    input  logic [7:0]        i_mem_dout,
    input  logic              i_mem_ack,
    output logic              o_timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t r_state, w_state_nxt;
    grant_t     r_last, w_last_nxt, w_pick;
    mem_cmd_t   r_cmd, w_cmd_nxt, w_cpu_cmd, w_ldr_cmd;
    logic       r_mem_req, w_mem_req_nxt;
    logic       r_cpu_ack, w_cpu_ack_nxt;
    logic [7:0] r_cpu_dout, w_cpu_dout_nxt;
    logic       r_timeout_err, w_terr_nxt;
    logic       w_ldr_full, w_ldr_ovf, w_flush, w_cpu_cand;

    // The session flag is informational only: a buffered byte drains regardless.
    logic w_unused_dl;
    assign w_unused_dl = i_ioctl_download;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`else
    logic [CNT_W-1:0] w_unused_tmo;
    assign w_unused_tmo = CNT_W'(TIMEOUT_CYC);
`endif

    msx_ldr_buf #(.ADDR_W(ADDR_W)) u_ldr_buf (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_wr    (i_ioctl_wr),
        .i_addr  (i_ioctl_addr),
        .i_din   (i_ioctl_dout),
        .i_flush (w_flush),
        .o_full  (w_ldr_full),
        .o_ovf   (w_ldr_ovf),
        .o_cmd   (w_ldr_cmd)
    );

    // Masking during the ack cycle keeps a still-held request from being granted twice.
    assign w_cpu_cand     = i_cpu_req & ~r_cpu_ack;
    assign w_cpu_cmd.we   = i_cpu_we;
    assign w_cpu_cmd.addr = ADDR_W_DEF'(i_cpu_addr);
    assign w_cpu_cmd.din  = i_cpu_din;
    assign w_pick         = pick_grant(w_cpu_cand, w_ldr_full, r_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last;
        w_cmd_nxt      = r_cmd;
        w_mem_req_nxt  = r_mem_req;
        w_cpu_ack_nxt  = 1'b0;
        w_cpu_dout_nxt = r_cpu_dout;
        w_terr_nxt     = r_timeout_err;
        w_flush        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_cpu_cand || w_ldr_full) begin
                    w_state_nxt   = BUSY;
                    w_mem_req_nxt = 1'b1;
                    w_last_nxt    = w_pick;
                    w_cmd_nxt     = (w_pick == GNT_CPU) ? w_cpu_cmd : w_ldr_cmd;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_cnt_nxt     = '0;
`endif
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (r_last == GNT_CPU) begin
                        w_cpu_ack_nxt = 1'b1;
                        if (!r_cmd.we)
                            w_cpu_dout_nxt = i_mem_dout;
                    end else begin
                        w_flush = 1'b1;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // Abandon the access after TIMEOUT_CYC cycles; the CPU reads an open bus.
                else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_terr_nxt    = 1'b1;
                    if (r_last == GNT_CPU) begin
                        w_cpu_ack_nxt  = 1'b1;
                        w_cpu_dout_nxt = 8'hFF;
                    end else begin
                        w_flush = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_last        <= GNT_CPU;
            r_cmd         <= '0;
            r_mem_req     <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_cpu_dout    <= 8'h00;
            r_timeout_err <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt         <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_last        <= w_last_nxt;
            r_cmd         <= w_cmd_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_cpu_ack     <= w_cpu_ack_nxt;
            r_cpu_dout    <= w_cpu_dout_nxt;
            r_timeout_err <= w_terr_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt         <= w_cnt_nxt;
`endif
        end
    end

    assign o_ioctl_wait  = w_ldr_full;
    assign o_ldr_ovf     = w_ldr_ovf;
    assign o_cpu_dout    = r_cpu_dout;
    assign o_cpu_ack     = r_cpu_ack;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_cmd.we;
    assign o_mem_addr    = ADDR_W'(r_cmd.addr);
    assign o_mem_din     = r_cmd.din;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
// Directed bench for msx_mem_arbiter: per-cycle vector table plus hand sequences for multi-cycle cases.
module tb_msx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, dl, iwr, creq, cwe, mack;
    logic [24:0] iaddr, caddr;
    logic [7:0]  idat, cdin, mdout;
    logic        o_wait, o_ovf, o_cack, o_mreq, o_mwe, o_terr;
    logic [7:0]  o_cdout, o_mdin;
    logic [24:0] o_maddr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    msx_mem_arbiter #(.ADDR_W(25), .TIMEOUT_CYC(8)) dut (
        .i_clk_sys        (clk),
        .i_reset          (rst),
        .i_ioctl_download (dl),
        .i_ioctl_wr       (iwr),
        .i_ioctl_addr     (iaddr),
        .i_ioctl_dout     (idat),
        .o_ioctl_wait     (o_wait),
        .o_ldr_ovf        (o_ovf),
        .i_cpu_req        (creq),
        .i_cpu_we         (cwe),
        .i_cpu_addr       (caddr),
        .i_cpu_din        (cdin),
        .o_cpu_dout       (o_cdout),
        .o_cpu_ack        (o_cack),
        .o_mem_req        (o_mreq),
        .o_mem_we         (o_mwe),
        .o_mem_addr       (o_maddr),
        .o_mem_din        (o_mdin),
        .i_mem_dout       (mdout),
        .i_mem_ack        (mack),
        .o_timeout_err    (o_terr)
    );

    typedef struct {
        logic rst, iwr; logic [24:0] ia; logic [7:0] id;
        logic cr, cw; logic [24:0] ca; logic [7:0] cd;
        logic ma; logic [7:0] md;
        logic ew, eo, eack; logic [7:0] ecd;
        logic emr, emw; logic [24:0] ema; logic [7:0] emd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic w, input logic [24:0] ia, input logic [7:0] id,
        input logic cr, input logic cw, input logic [24:0] ca, input logic [7:0] cd,
        input logic ma, input logic [7:0] md,
        input logic ew, input logic eo, input logic eack, input logic [7:0] ecd,
        input logic emr, input logic emw, input logic [24:0] ema, input logic [7:0] emd);
        vec_t v;
        v.rst = r; v.iwr = w; v.ia = ia; v.id = id;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.ma = ma; v.md = md;
        v.ew = ew; v.eo = eo; v.eack = eack; v.ecd = ecd;
        v.emr = emr; v.emw = emw; v.ema = ema; v.emd = emd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t        tv[20];
    logic        glog[4];
    logic [24:0] alog[4];
    int          ng, ncpu, left;
    logic        bad;

    initial begin
        rst = 1'b1; dl = 1'b1; iwr = 1'b0; iaddr = '0; idat = '0;
        creq = 1'b0; cwe = 1'b0; caddr = '0; cdin = '0; mack = 1'b0; mdout = '0;

        //         rst iwr ia     id     cr cw ca       cd     ma md     | wt ov ak cdout  mr mw maddr    mdin
        tv[0]  = mk(1, 0, 'h0,  'h00,  0, 0, 'h0,    'h00,  0, 'h00,    0, 0, 0, 'h00,  0, 0, 'h0,    'h00);
        tv[1]  = mk(0, 0, 'h0,  'h00,  1, 0, 'h100,  'h00,  0, 'h00,    0, 0, 0, 'h00,  1, 0, 'h100,  'h00);
        tv[2]  = mk(0, 0, 'h0,  'h00,  1, 0, 'h100,  'h00,  0, 'h00,    0, 0, 0, 'h00,  1, 0, 'h100,  'h00);
        tv[3]  = mk(0, 0, 'h0,  'h00,  1, 0, 'h100,  'h00,  1, 'h5A,    0, 0, 1, 'h5A,  0, 0, 'h100,  'h00);
        tv[4]  = mk(0, 0, 'h0,  'h00,  1, 0, 'h100,  'h00,  0, 'h00,    0, 0, 0, 'h5A,  0, 0, 'h100,  'h00);
        tv[5]  = mk(0, 0, 'h0,  'h00,  0, 0, 'h100,  'h00,  0, 'h00,    0, 0, 0, 'h5A,  0, 0, 'h100,  'h00);
        tv[6]  = mk(0, 0, 'h0,  'h00,  1, 1, 'h3FFF, 'hAA,  0, 'h00,    0, 0, 0, 'h5A,  1, 1, 'h3FFF, 'hAA);
        tv[7]  = mk(0, 0, 'h0,  'h00,  1, 1, 'h3FFF, 'hAA,  0, 'h00,    0, 0, 0, 'h5A,  1, 1, 'h3FFF, 'hAA);
        tv[8]  = mk(0, 0, 'h0,  'h00,  1, 1, 'h3FFF, 'hAA,  1, 'h11,    0, 0, 1, 'h5A,  0, 1, 'h3FFF, 'hAA);
        tv[9]  = mk(0, 0, 'h0,  'h00,  1, 1, 'h3FFF, 'hAA,  0, 'h00,    0, 0, 0, 'h5A,  0, 1, 'h3FFF, 'hAA);
        tv[10] = mk(0, 0, 'h0,  'h00,  0, 1, 'h3FFF, 'hAA,  0, 'h00,    0, 0, 0, 'h5A,  0, 1, 'h3FFF, 'hAA);
        tv[11] = mk(0, 0, 'h0,  'h00,  1, 0, 'h20,   'hAA,  0, 'h00,    0, 0, 0, 'h5A,  1, 0, 'h20,   'hAA);
        tv[12] = mk(0, 0, 'h0,  'h00,  1, 0, 'h20,   'hAA,  1, 'h77,    0, 0, 1, 'h77,  0, 0, 'h20,   'hAA);
        tv[13] = mk(0, 0, 'h0,  'h00,  0, 0, 'h20,   'hAA,  0, 'h00,    0, 0, 0, 'h77,  0, 0, 'h20,   'hAA);
        tv[14] = mk(0, 1, 'h10, 'hC3,  0, 0, 'h0,    'h00,  0, 'h00,    1, 0, 0, 'h77,  0, 0, 'h20,   'hAA);
        tv[15] = mk(0, 1, 'h11, 'h99,  0, 0, 'h0,    'h00,  0, 'h00,    1, 1, 0, 'h77,  1, 1, 'h10,   'hC3);
        tv[16] = mk(0, 0, 'h0,  'h00,  0, 0, 'h0,    'h00,  0, 'h00,    1, 1, 0, 'h77,  1, 1, 'h10,   'hC3);
        tv[17] = mk(0, 0, 'h0,  'h00,  0, 0, 'h0,    'h00,  1, 'h55,    0, 1, 0, 'h77,  0, 1, 'h10,   'hC3);
        tv[18] = mk(0, 0, 'h0,  'h00,  0, 0, 'h0,    'h00,  0, 'h00,    0, 1, 0, 'h77,  0, 1, 'h10,   'hC3);
        tv[19] = mk(1, 0, 'h0,  'h00,  0, 0, 'h0,    'h00,  0, 'h00,    0, 0, 0, 'h00,  0, 0, 'h0,    'h00);

        for (int i = 0; i < 20; i++) begin
            rst = tv[i].rst; iwr = tv[i].iwr; iaddr = tv[i].ia; idat = tv[i].id;
            creq = tv[i].cr; cwe = tv[i].cw; caddr = tv[i].ca; cdin = tv[i].cd;
            mack = tv[i].ma; mdout = tv[i].md;
            step();
            chk($sformatf("v%0d.wait", i),   32'(o_wait),  32'(tv[i].ew));
            chk($sformatf("v%0d.ovf", i),    32'(o_ovf),   32'(tv[i].eo));
            chk($sformatf("v%0d.cack", i),   32'(o_cack),  32'(tv[i].eack));
            chk($sformatf("v%0d.cdout", i),  32'(o_cdout), 32'(tv[i].ecd));
            chk($sformatf("v%0d.mreq", i),   32'(o_mreq),  32'(tv[i].emr));
            chk($sformatf("v%0d.mwe", i),    32'(o_mwe),   32'(tv[i].emw));
            chk($sformatf("v%0d.maddr", i),  32'(o_maddr), 32'(tv[i].ema));
            chk($sformatf("v%0d.mdin", i),   32'(o_mdin),  32'(tv[i].emd));
            chk($sformatf("v%0d.terr", i),   32'(o_terr),  32'd0);
        end

        // Reset while BUSY with a loader byte buffered, then a stray mem_ack.
        rst = 1'b0; iwr = 1'b1; iaddr = 25'h50; idat = 8'h66;
        creq = 1'b1; cwe = 1'b0; caddr = 25'h40;
        step();
        chk("rstb.mreq", 32'(o_mreq), 32'd1);
        chk("rstb.wait", 32'(o_wait), 32'd1);
        iwr = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rstb.mreq_drop", 32'(o_mreq), 32'd0);
        chk("rstb.wait_clr",  32'(o_wait), 32'd0);
        rst = 1'b0; creq = 1'b0; mack = 1'b1; mdout = 8'hEE;
        step();
        chk("rstb.late_ack_cack", 32'(o_cack), 32'd0);
        chk("rstb.late_ack_mreq", 32'(o_mreq), 32'd0);
        mack = 1'b0;
        step();
        chk("rstb.idle_cack", 32'(o_cack),  32'd0);
        chk("rstb.idle_dout", 32'(o_cdout), 32'd0);

        // Both pending: grants alternate; loader refills on its own completion edge.
        iwr = 1'b1; iaddr = 25'h1000; idat = 8'h10;
        step();
        iwr = 1'b0; creq = 1'b1; cwe = 1'b0; caddr = 25'h2000;
        ng = 0; ncpu = 0; left = 1;
        for (int c = 0; c < 40 && (ng < 4 || creq); c++) begin
            step();
            if (o_cack) begin
                ncpu++;
                if (ncpu == 2) creq = 1'b0;
            end
            if (o_mreq && !mack) begin
                if (ng < 4) begin
                    glog[ng] = o_mwe;
                    alog[ng] = o_maddr;
                end
                ng++;
                mack = 1'b1; mdout = 8'hE0;
                if (o_mwe && left > 0) begin
                    iwr = 1'b1; iaddr = 25'h1001; idat = 8'h11; left--;
                end
            end else begin
                mack = 1'b0; iwr = 1'b0;
            end
        end
        mack = 1'b0; iwr = 1'b0; creq = 1'b0;
        chk("alt.num_grants", 32'(ng), 32'd4);
        chk("alt.cpu_acks", 32'(ncpu), 32'd2);
        chk("alt.g0_ldr", 32'(glog[0]), 32'd1);
        chk("alt.g1_cpu", 32'(glog[1]), 32'd0);
        chk("alt.g2_ldr", 32'(glog[2]), 32'd1);
        chk("alt.g3_cpu", 32'(glog[3]), 32'd0);
        chk("alt.a0", 32'(alog[0]), 32'h1000);
        chk("alt.a1", 32'(alog[1]), 32'h2000);
        chk("alt.a2", 32'(alog[2]), 32'h1001);
        chk("alt.a3", 32'(alog[3]), 32'h2000);
        step();
        chk("alt.no_ovf", 32'(o_ovf), 32'd0);
        chk("alt.wait_clr", 32'(o_wait), 32'd0);

        // Watchdog behaviour on an unanswered CPU read.
        creq = 1'b1; cwe = 1'b0; caddr = 25'h80;
        step();
        chk("tmo.mreq", 32'(o_mreq), 32'd1);
`ifdef MEM_ARB_TIMEOUT_EN
        bad = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            if (o_cack || !o_mreq || o_terr) bad = 1'b1;
        end
        chk("tmo.early", 32'(bad), 32'd0);
        step();
        chk("tmo.cack", 32'(o_cack), 32'd1);
        chk("tmo.dout", 32'(o_cdout), 32'hFF);
        chk("tmo.terr", 32'(o_terr), 32'd1);
        chk("tmo.mreq_drop", 32'(o_mreq), 32'd0);
        creq = 1'b0;
        repeat (5) step();
        chk("tmo.sticky", 32'(o_terr), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("tmo.rst_clr", 32'(o_terr), 32'd0);
`else
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_cack || !o_mreq || o_terr) bad = 1'b1;
        end
        chk("wait.held", 32'(bad), 32'd0);
        mack = 1'b1; mdout = 8'h3C;
        step();
        mack = 1'b0; creq = 1'b0;
        chk("wait.cack", 32'(o_cack), 32'd1);
        chk("wait.dout", 32'(o_cdout), 32'h3C);
        chk("wait.terr", 32'(o_terr), 32'd0);
`endif
        step();
        chk("end.mreq", 32'(o_mreq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
